// File: rtl/inorder_issue_queue_if.sv
// Dispatch, issue, writeback-wakeup and redirect signals of the in-order issue queue.
// master = dispatch/execute/ROB side, slave = the queue itself.
interface inorder_issue_queue_if #(
  parameter int DEPTH     = 8,
  parameter int WB_PORTS  = 2,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 160
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       enq_valid;
  logic                       enq_ready;
  logic [PREG_W-1:0]          enq_prs1;
  logic [PREG_W-1:0]          enq_prs2;
  logic                       enq_src1_is_reg;
  logic                       enq_src2_is_reg;
  logic                       enq_src1_busy;
  logic                       enq_src2_busy;
  logic                       enq_robidx_flag;
  logic [ROB_W-1:0]           enq_robidx;
  logic [PAYLOAD_W-1:0]       enq_payload;

  logic                       deq_valid;
  logic                       deq_ready;
  logic [PREG_W-1:0]          deq_prs1;
  logic [PREG_W-1:0]          deq_prs2;
  logic                       deq_src1_is_reg;
  logic                       deq_src2_is_reg;
  logic                       deq_robidx_flag;
  logic [ROB_W-1:0]           deq_robidx;
  logic [PAYLOAD_W-1:0]       deq_payload;

  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*PREG_W-1:0] wb_prd;

  logic                       flush_valid;
  logic                       flush_robidx_flag;
  logic [ROB_W-1:0]           flush_robidx;

  logic [CNT_W-1:0]           count;

  modport master (
    output enq_valid, enq_prs1, enq_prs2, enq_src1_is_reg, enq_src2_is_reg,
           enq_src1_busy, enq_src2_busy, enq_robidx_flag, enq_robidx, enq_payload,
           deq_ready, wb_valid, wb_prd, flush_valid, flush_robidx_flag, flush_robidx,
    input  enq_ready, deq_valid, deq_prs1, deq_prs2, deq_src1_is_reg, deq_src2_is_reg,
           deq_robidx_flag, deq_robidx, deq_payload, count
  );

  modport slave (
    input  enq_valid, enq_prs1, enq_prs2, enq_src1_is_reg, enq_src2_is_reg,
           enq_src1_busy, enq_src2_busy, enq_robidx_flag, enq_robidx, enq_payload,
           deq_ready, wb_valid, wb_prd, flush_valid, flush_robidx_flag, flush_robidx,
    output enq_ready, deq_valid, deq_prs1, deq_prs2, deq_src1_is_reg, deq_src2_is_reg,
           deq_robidx_flag, deq_robidx, deq_payload, count
  );
endinterface

// File: rtl/inorder_issue_queue.sv
// In-order issue queue: circular FIFO with writeback wakeup, selective redirect flush and a
// registered issue stage. Optional macro ISSUE_QUEUE_ENQ_BYPASS_EN folds same-cycle wakeups into enqueue.
module inorder_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int WB_PORTS  = 2,
  parameter int PREG_W    = 7,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 160
) (
  input  logic                  clock,
  input  logic                  reset_n,
  inorder_issue_queue_if.slave  io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic is_younger(input logic f_flag, input logic [ROB_W-1:0] f_idx,
                                      input logic x_flag, input logic [ROB_W-1:0] x_idx);
    return (f_flag ^ x_flag) ^ (f_idx < x_idx);
  endfunction

  function automatic logic wb_match(input logic [WB_PORTS-1:0] v,
                                    input logic [WB_PORTS*PREG_W-1:0] prd,
                                    input logic [PREG_W-1:0] prs);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) hit |= v[k] & (prd[k*PREG_W +: PREG_W] == prs);
    return hit;
  endfunction

  logic [PREG_W-1:0]    prs1_mem    [DEPTH];
  logic [PREG_W-1:0]    prs2_mem    [DEPTH];
  logic                 src1_is_reg_mem [DEPTH];
  logic                 src2_is_reg_mem [DEPTH];
  logic                 rob_flag_mem [DEPTH];
  logic [ROB_W-1:0]     rob_idx_mem [DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

  logic [PTR_W:0]   enq_ptr_reg, enq_ptr_next;
  logic [PTR_W:0]   deq_ptr_reg, deq_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] survivors;

  logic [DEPTH-1:0] entry_valid, entry_busy1, entry_busy2, killed, issued;
  logic [PTR_W-1:0] head_idx, enq_idx;
  logic             enq_ready, enq_fire, head_ready, issue;
  logic             enq_busy1, enq_busy2;

  logic                 deq_valid_reg;
  logic [PREG_W-1:0]    deq_prs1_reg, deq_prs2_reg;
  logic                 deq_src1_is_reg_reg, deq_src2_is_reg_reg;
  logic                 deq_robidx_flag_reg;
  logic [ROB_W-1:0]     deq_robidx_reg;
  logic [PAYLOAD_W-1:0] deq_payload_reg;

  assign head_idx  = deq_ptr_reg[PTR_W-1:0];
  assign enq_idx   = enq_ptr_reg[PTR_W-1:0];
  assign enq_ready = (count_reg != CNT_W'(DEPTH)) & ~io.flush_valid;
  assign enq_fire  = io.enq_valid & enq_ready;

  // Busy bits only gate readiness from the registered copy, so a wakeup this cycle helps next cycle.
  assign head_ready = entry_valid[head_idx] & ~killed[head_idx]
                    & ~entry_busy1[head_idx] & ~entry_busy2[head_idx];
  assign issue      = head_ready & (~deq_valid_reg | io.deq_ready);

`ifdef ISSUE_QUEUE_ENQ_BYPASS_EN
  assign enq_busy1 = io.enq_src1_busy & io.enq_src1_is_reg
                   & ~wb_match(io.wb_valid, io.wb_prd, io.enq_prs1);
  assign enq_busy2 = io.enq_src2_busy & io.enq_src2_is_reg
                   & ~wb_match(io.wb_valid, io.wb_prd, io.enq_prs2);
`else
  assign enq_busy1 = io.enq_src1_busy & io.enq_src1_is_reg;
  assign enq_busy2 = io.enq_src2_busy & io.enq_src2_is_reg;
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic valid_reg, busy1_reg, busy2_reg;
    logic wake1, wake2, enq_here, issue_here;

    assign wake1      = src1_is_reg_mem[gi] & wb_match(io.wb_valid, io.wb_prd, prs1_mem[gi]);
    assign wake2      = src2_is_reg_mem[gi] & wb_match(io.wb_valid, io.wb_prd, prs2_mem[gi]);
    assign enq_here   = enq_fire & (enq_idx == PTR_W'(gi));
    assign issue_here = issue & (head_idx == PTR_W'(gi));
    assign killed[gi] = io.flush_valid & valid_reg
                      & is_younger(io.flush_robidx_flag, io.flush_robidx,
                                   rob_flag_mem[gi], rob_idx_mem[gi]);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg <= 1'b0;
        busy1_reg <= 1'b0;
        busy2_reg <= 1'b0;
      end else begin
        valid_reg <= (valid_reg & ~killed[gi] & ~issue_here) | enq_here;
        busy1_reg <= enq_here ? enq_busy1 : (busy1_reg & ~wake1);
        busy2_reg <= enq_here ? enq_busy2 : (busy2_reg & ~wake2);
      end
    end

    assign entry_valid[gi] = valid_reg;
    assign entry_busy1[gi] = busy1_reg;
    assign entry_busy2[gi] = busy2_reg;
    assign issued[gi]      = issue_here;
  end

  always_comb begin
    survivors = '0;
    for (int i = 0; i < DEPTH; i++)
      survivors += CNT_W'(entry_valid[i] & ~killed[i] & ~issued[i]);
  end

  // Killed entries always form the youngest tail, so survivors are contiguous from the new head.
  always_comb begin
    deq_ptr_next = deq_ptr_reg + (PTR_W+1)'(issue);
    enq_ptr_next = enq_ptr_reg + (PTR_W+1)'(enq_fire);
    count_next   = count_reg + CNT_W'(enq_fire) - CNT_W'(issue);
    if (io.flush_valid) begin
      enq_ptr_next = deq_ptr_next + survivors;
      count_next   = survivors;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
      count_reg   <= '0;
    end else begin
      enq_ptr_reg <= enq_ptr_next;
      deq_ptr_reg <= deq_ptr_next;
      count_reg   <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      prs1_mem[enq_idx]        <= io.enq_prs1;
      prs2_mem[enq_idx]        <= io.enq_prs2;
      src1_is_reg_mem[enq_idx] <= io.enq_src1_is_reg;
      src2_is_reg_mem[enq_idx] <= io.enq_src2_is_reg;
      rob_flag_mem[enq_idx]    <= io.enq_robidx_flag;
      rob_idx_mem[enq_idx]     <= io.enq_robidx;
      payload_mem[enq_idx]     <= io.enq_payload;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deq_valid_reg       <= 1'b0;
      deq_prs1_reg        <= '0;
      deq_prs2_reg        <= '0;
      deq_src1_is_reg_reg <= 1'b0;
      deq_src2_is_reg_reg <= 1'b0;
      deq_robidx_flag_reg <= 1'b0;
      deq_robidx_reg      <= '0;
      deq_payload_reg     <= '0;
    end else if (issue) begin
      deq_valid_reg       <= 1'b1;
      deq_prs1_reg        <= prs1_mem[head_idx];
      deq_prs2_reg        <= prs2_mem[head_idx];
      deq_src1_is_reg_reg <= src1_is_reg_mem[head_idx];
      deq_src2_is_reg_reg <= src2_is_reg_mem[head_idx];
      deq_robidx_flag_reg <= rob_flag_mem[head_idx];
      deq_robidx_reg      <= rob_idx_mem[head_idx];
      deq_payload_reg     <= payload_mem[head_idx];
    end else if (deq_valid_reg & io.deq_ready) begin
      deq_valid_reg <= 1'b0;
    end else if (deq_valid_reg & io.flush_valid
                 & is_younger(io.flush_robidx_flag, io.flush_robidx,
                              deq_robidx_flag_reg, deq_robidx_reg)) begin
      deq_valid_reg <= 1'b0;
    end
  end

  assign io.enq_ready       = enq_ready;
  assign io.count           = count_reg;
  assign io.deq_valid       = deq_valid_reg;
  assign io.deq_prs1        = deq_prs1_reg;
  assign io.deq_prs2        = deq_prs2_reg;
  assign io.deq_src1_is_reg = deq_src1_is_reg_reg;
  assign io.deq_src2_is_reg = deq_src2_is_reg_reg;
  assign io.deq_robidx_flag = deq_robidx_flag_reg;
  assign io.deq_robidx      = deq_robidx_reg;
  assign io.deq_payload     = deq_payload_reg;
endmodule

// File: tb/tb_inorder_issue_queue.sv
// Directed and random stimulus for inorder_issue_queue, checked every cycle against a
// queue-based model of the issue rules.
module tb_inorder_issue_queue;
  localparam int DEPTH = 8, WB_PORTS = 2, PREG_W = 7, ROB_W = 6, PAYLOAD_W = 160;

  typedef struct packed {
    logic [6:0]   prs1, prs2;
    logic         r1, r2, b1, b2;
    logic [6:0]   pos;
    logic [159:0] pay;
  } uop_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  inorder_issue_queue_if #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .PREG_W(PREG_W),
                           .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) io();
  inorder_issue_queue #(.DEPTH(DEPTH), .WB_PORTS(WB_PORTS), .PREG_W(PREG_W),
                        .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clock(clock), .reset_n(reset_n), .io(io));

  int checks = 0, failures = 0;
  uop_t q[$];
  uop_t out_m;
  bit out_v = 0;
  bit [6:0] rob_ptr = 0;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Age by modular distance in the 128-entry ROB space; the live window is far below 64.
  function automatic bit younger_m(bit [6:0] f, bit [6:0] x);
    bit [6:0] d;
    d = x - f;
    return d != 0 && d < 64;
  endfunction

  function automatic bit wb_hit(bit [6:0] p);
    for (int k = 0; k < WB_PORTS; k++)
      if (io.wb_valid[k] && io.wb_prd[k*PREG_W +: PREG_W] == p) return 1;
    return 0;
  endfunction

  task automatic set_idle();
    io.enq_valid = 0; io.enq_prs1 = 0; io.enq_prs2 = 0;
    io.enq_src1_is_reg = 0; io.enq_src2_is_reg = 0;
    io.enq_src1_busy = 0; io.enq_src2_busy = 0;
    io.enq_robidx_flag = 0; io.enq_robidx = 0; io.enq_payload = 0;
    io.wb_valid = 0; io.wb_prd = 0;
    io.flush_valid = 0; io.flush_robidx_flag = 0; io.flush_robidx = 0;
  endtask

  task automatic drive_enq(input bit b1, input bit b2, input bit [6:0] p1, input bit [6:0] p2,
                           input bit r1, input bit r2);
    io.enq_valid = 1; io.enq_prs1 = p1; io.enq_prs2 = p2;
    io.enq_src1_is_reg = r1; io.enq_src2_is_reg = r2;
    io.enq_src1_busy = b1; io.enq_src2_busy = b2;
    {io.enq_robidx_flag, io.enq_robidx} = rob_ptr;
    io.enq_payload = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic drive_wb(input int port, input bit [6:0] p);
    io.wb_valid[port] = 1;
    io.wb_prd[port*PREG_W +: PREG_W] = p;
  endtask

  task automatic drive_flush(input bit [6:0] p);
    io.flush_valid = 1;
    {io.flush_robidx_flag, io.flush_robidx} = p;
  endtask

  // Called just after a rising edge with inputs applied: check, advance the model, cross one edge.
  task automatic step();
    bit enq_rdy, fire, flush, head_ok, issue;
    bit [6:0] fpos;
    uop_t e;
    uop_t nq[$];
    #1;
    enq_rdy = q.size() < DEPTH && !io.flush_valid;
    check_eq("enq_ready", io.enq_ready, enq_rdy);
    check_eq("count", io.count, q.size());
    check_eq("deq_valid", io.deq_valid, out_v);
    if (out_v) begin
      check_eq("deq_robidx", {io.deq_robidx_flag, io.deq_robidx}, out_m.pos);
      check_eq("deq_prs", {io.deq_prs1, io.deq_prs2}, {out_m.prs1, out_m.prs2});
      check_eq("deq_is_reg", {io.deq_src1_is_reg, io.deq_src2_is_reg}, {out_m.r1, out_m.r2});
      check_eq("deq_payload", io.deq_payload, out_m.pay);
    end
    fire  = io.enq_valid && enq_rdy;
    flush = io.flush_valid;
    fpos  = {io.flush_robidx_flag, io.flush_robidx};
    head_ok = q.size() > 0 && !q[0].b1 && !q[0].b2 && !(flush && younger_m(fpos, q[0].pos));
    issue = head_ok && (!out_v || io.deq_ready);
    if (issue) begin
      out_m = q.pop_front();
      out_v = 1;
    end else if (out_v && io.deq_ready) out_v = 0;
    else if (flush && out_v && younger_m(fpos, out_m.pos)) out_v = 0;
    foreach (q[i]) begin
      e = q[i];
      if (!(flush && younger_m(fpos, e.pos))) begin
        if (e.r1 && wb_hit(e.prs1)) e.b1 = 0;
        if (e.r2 && wb_hit(e.prs2)) e.b2 = 0;
        nq.push_back(e);
      end
    end
    if (fire) begin
      e.prs1 = io.enq_prs1; e.prs2 = io.enq_prs2;
      e.r1 = io.enq_src1_is_reg; e.r2 = io.enq_src2_is_reg;
      e.b1 = io.enq_src1_busy && e.r1;
      e.b2 = io.enq_src2_busy && e.r2;
`ifdef ISSUE_QUEUE_ENQ_BYPASS_EN
      if (wb_hit(e.prs1)) e.b1 = 0;
      if (wb_hit(e.prs2)) e.b2 = 0;
`endif
      e.pos = {io.enq_robidx_flag, io.enq_robidx};
      e.pay = io.enq_payload;
      nq.push_back(e);
      rob_ptr++;
    end
    if (flush) rob_ptr = fpos + 7'd1;
    q = nq;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      step();
    end
  endtask

  initial begin
    set_idle();
    io.deq_ready = 0;
    #3;
    check_eq("rst_deq_valid", io.deq_valid, 0);
    check_eq("rst_count", io.count, 0);
    check_eq("rst_deq_robidx", {io.deq_robidx_flag, io.deq_robidx}, 0);
    check_eq("rst_deq_payload", io.deq_payload, 0);
    check_eq("rst_deq_prs", {io.deq_prs1, io.deq_prs2, io.deq_src1_is_reg, io.deq_src2_is_reg}, 0);
    #10 reset_n = 1;
    @(posedge clock); #1;

    // Back-to-back stream of ready micro-ops.
    io.deq_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_idle();
      drive_enq(0, 0, 7'(i), 7'(i + 1), 1, 1);
      step();
    end
    idle(4);

    // Fill with the execute port stalled, then wrap the pointer.
    io.deq_ready = 0;
    for (int i = 0; i < 11; i++) begin
      set_idle();
      drive_enq(0, 0, 7'(i), 7'(i), i[0], 1);
      step();
    end
    check_eq("full_enq_ready", io.enq_ready, 0);
    io.deq_ready = 1;
    idle(1);
    io.deq_ready = 0;
    set_idle();
    drive_enq(0, 0, 7'h33, 7'h34, 1, 0);
    step();
    io.deq_ready = 1;
    idle(12);

    // Head blocked on prs1 = 0x15 until port 1 writes it back.
    set_idle(); drive_enq(1, 0, 7'h15, 7'h01, 1, 1); step();
    set_idle(); drive_enq(0, 0, 7'h02, 7'h03, 1, 1); step();
    idle(4);
    set_idle(); drive_wb(1, 7'h15); step();
    check_eq("wake_not_yet", io.deq_valid, 0);
    idle(1);
    check_eq("wake_issued", io.deq_valid, 1);
    idle(4);

    // Selective flush of robidx 5 and 6 behind a busy head.
    rob_ptr = 7'd3;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      drive_enq(i == 0, 0, 7'h11, 7'h12, 1, 1);
      step();
    end
    set_idle(); drive_flush(7'd4); step();
    check_eq("flush_count", io.count, 2);
    set_idle(); drive_enq(0, 0, 7'h05, 7'h06, 1, 1); step();
    set_idle(); drive_wb(0, 7'h11); step();
    idle(6);

    // Output register holding robidx 9 against a flush at 7, then at 9.
    for (int rep = 0; rep < 2; rep++) begin
      rob_ptr = 7'd9;
      io.deq_ready = 0;
      set_idle(); drive_enq(0, 0, 7'h07, 7'h08, 1, 1); step();
      idle(2);
      set_idle(); drive_flush(rep == 0 ? 7'd7 : 7'd9); step();
      check_eq("out_flush", io.deq_valid, rep == 1);
      idle(3);
      io.deq_ready = 1;
      idle(2);
    end

    // Enqueue coinciding with the writeback of its source.
    set_idle();
    drive_enq(1, 0, 7'h20, 7'h01, 1, 1);
    drive_wb(0, 7'h20);
    step();
    idle(1);
`ifdef ISSUE_QUEUE_ENQ_BYPASS_EN
    check_eq("bypass_issue", io.deq_valid, 1);
`else
    idle(4);
    check_eq("no_bypass_blocked", io.deq_valid, 0);
    set_idle(); drive_wb(1, 7'h20); step();
`endif
    idle(4);

    // Random traffic with an asynchronous reset dropped in midway.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        set_idle();
        #1 reset_n = 0;
        #1;
        check_eq("midrst_deq_valid", io.deq_valid, 0);
        check_eq("midrst_count", io.count, 0);
        check_eq("midrst_enq_ready", io.enq_ready, 1);
        q.delete(); out_v = 0; rob_ptr = 0;
        #1 reset_n = 1;
        @(posedge clock); #1;
      end
      set_idle();
      io.deq_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 7)
        drive_enq($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                  7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8);
      for (int k = 0; k < WB_PORTS; k++)
        if ($urandom_range(0, 9) < 5) drive_wb(k, 7'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) < 3)
        drive_flush(rob_ptr - 7'd1 - 7'($urandom_range(0, 9)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
